// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply (shift-add) / restoring divide, WIDTH cycles per op
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
    state_t state;
    logic [CW-1:0] count;
    logic [WIDTH-1:0] ma, mb, hi, lo, hi_n, lo_n, abs_a, abs_b, quo, res_n;
    logic [WIDTH:0] sum, shifted, top;
    logic [2*WIDTH-1:0] prod;
    logic neg, ge, exc_n;
    always_comb begin
        abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        sum = {1'b0, hi} + {1'b0, lo[0] ? ma : '0};
        shifted = {hi, lo[WIDTH-1]};
        ge = shifted >= {1'b0, mb};
        hi_n = state == MULT ? sum[WIDTH:1] : ge ? shifted[WIDTH-1:0] - mb : shifted[WIDTH-1:0];
        lo_n = state == MULT ? {sum[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], ge};
        prod = neg ? -{hi_n, lo_n} : {hi_n, lo_n};
        quo = neg ? -lo_n : lo_n;
        top = prod[2*WIDTH-1:WIDTH-1];
        res_n = state == MULT ? prod[WIDTH-1:0] : mb == '0 ? '0 : quo;
        // an unsigned quotient of 2^(W-1) with a positive sign is the only divide overflow
        exc_n = state == MULT ? !(&top || ~|top) : (mb == '0) || (!neg && lo_n[WIDTH-1]);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            ma <= '0;
            mb <= '0;
            hi <= '0;
            lo <= '0;
            neg <= 1'b0;
            data_result <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE: if (ctrl_MULT || ctrl_DIV) begin
                    state <= ctrl_MULT ? MULT : DIV;
                    busy <= 1'b1;
                    count <= '0;
                    hi <= '0;
                    lo <= ctrl_MULT ? abs_b : abs_a;
                    ma <= abs_a;
                    mb <= abs_b;
                    neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                end
                MULT, DIV: begin
                    hi <= hi_n;
                    lo <= lo_n;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        data_resultRDY <= 1'b1;
                        data_result <= res_n;
                        data_exception <= exc_n;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit latency, arithmetic and control behaviour
module tb_mult_div_unit;
    logic clock = 1'b0;
    logic reset, ctrl_MULT, ctrl_DIV, data_exception, data_resultRDY, busy;
    logic [31:0] data_operandA, data_operandB, data_result;
    int tests = 0;
    int fails = 0;
    logic [32:0] sb[$];
    logic [32:0] mon_exp;
    logic [31:0] prev_r;
    logic prev_e;

    always #5 clock = ~clock;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY), .busy(busy)
    );

    always @(negedge clock) if (data_resultRDY === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL rdy_unexpected: got rdy with result=%h exc=%b, required no rdy", data_result, data_exception);
        end else begin
            mon_exp = sb.pop_front();
            if ({data_exception, data_result} !== mon_exp) begin
                fails++;
                $display("FAIL result: got exc=%b result=%h, required exc=%b result=%h",
                         data_exception, data_result, mon_exp[32], mon_exp[31:0]);
            end
        end
    end

    function automatic logic [32:0] model(input logic m, input logic [31:0] a, input logic [31:0] b);
        longint p;
        if (m) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return {p != longint'($signed(p[31:0])), p[31:0]};
        end
        if (b == 32'h0) return {1'b1, 32'h0};
        p = longint'($signed(a)) / longint'($signed(b));
        return {p > 64'sd2147483647, p[31:0]};
    endfunction

    task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ee, input int poke);
        @(negedge clock);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_before_start: busy=%b, required 0", busy);
        end
        ctrl_MULT = m;
        ctrl_DIV = d;
        data_operandA = a;
        data_operandB = b;
        sb.push_back({ee, er});
        for (int k = 1; k <= 33; k++) begin
            @(negedge clock);
            ctrl_MULT = 1'b0;
            ctrl_DIV = (k == poke);
            data_operandA = $urandom;
            data_operandB = $urandom;
            tests++;
            if (busy !== 1'b1 || data_resultRDY !== (k == 33)) begin
                fails++;
                $display("FAIL busy_rdy cycle %0d: busy=%b rdy=%b, required busy=1 rdy=%b", k, busy, data_resultRDY, k == 33);
            end
            if (k <= 32) begin
                tests++;
                if ({data_exception, data_result} !== {prev_e, prev_r}) begin
                    fails++;
                    $display("FAIL hold cycle %0d: exc=%b result=%h, required exc=%b result=%h",
                             k, data_exception, data_result, prev_e, prev_r);
                end
            end
        end
        ctrl_DIV = 1'b0;
        prev_r = er;
        prev_e = ee;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(negedge clock);
        tests++;
        if ({busy, data_resultRDY, data_exception, data_result} !== 35'h0) begin
            fails++;
            $display("FAIL reset_state: busy=%b rdy=%b exc=%b result=%h, required all 0",
                     busy, data_resultRDY, data_exception, data_result);
        end
        reset = 1'b0;
        prev_r = '0;
        prev_e = 1'b0;
    endtask

    task automatic test_mult_basic();
        run_op(1, 0, 32'd7, -32'sd3, 32'hFFFFFFEB, 0, 0);
    endtask

    task automatic test_mult_overflow();
        run_op(1, 0, 32'h00010000, 32'h00010000, 32'h0, 1, 0);
        run_op(1, 0, -32'sd65536, 32'd32768, 32'h80000000, 0, 0);
        run_op(1, 0, 32'h80000000, 32'h80000000, 32'h0, 1, 0);
    endtask

    task automatic test_div_signs();
        run_op(0, 1, -32'sd17, 32'd5, 32'hFFFFFFFD, 0, 0);
        run_op(0, 1, 32'd17, -32'sd5, 32'hFFFFFFFD, 0, 0);
        run_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
        run_op(0, 1, 32'h80000000, 32'd1, 32'h80000000, 0, 0);
    endtask

    task automatic test_div_by_zero();
        run_op(0, 1, 32'd100, 32'd0, 32'h0, 1, 0);
    endtask

    task automatic test_start_ignored();
        run_op(1, 0, 32'd9, 32'd11, 32'd99, 0, 10);
    endtask

    task automatic test_reset_abort();
        @(negedge clock);
        ctrl_MULT = 1'b1;
        data_operandA = 32'd5;
        data_operandB = 32'd5;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            ctrl_MULT = 1'b0;
            reset = (k == 20);
        end
        @(negedge clock);
        reset = 1'b0;
        tests++;
        if ({busy, data_resultRDY, data_exception, data_result} !== 35'h0) begin
            fails++;
            $display("FAIL reset_abort: busy=%b rdy=%b exc=%b result=%h, required all 0",
                     busy, data_resultRDY, data_exception, data_result);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            tests++;
            if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL abort_quiet %0d: rdy=%b busy=%b, required 0 0", k, data_resultRDY, busy);
            end
        end
        prev_r = '0;
        prev_e = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_op(1, 1, 32'd6, 32'd3, 32'd18, 0, 0);
        run_op(0, 1, 32'd100, 32'd7, 32'd14, 0, 0);
    endtask

    task automatic test_random();
        logic m;
        logic [31:0] a, b;
        logic [32:0] e;
        for (int i = 0; i < 10; i++) begin
            m = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : 32'($urandom);
            b = ($urandom_range(0, 4) == 0) ? 32'h0 : ($urandom_range(0, 1) == 0) ? 32'($signed(8'($urandom))) : 32'($urandom);
            e = model(m, a, b);
            run_op(m, !m, a, b, e[31:0], e[32], 0);
        end
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_mult_overflow();
        test_div_signs();
        test_div_by_zero();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random();
        repeat (3) @(negedge clock);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
